// File: rtl/apb_mem_slave.sv
// apb_mem_slave
//   APB-style slave that exposes a DEPTH-word, DATA_W-bit memory with
//   byte-lane write strobes and a fixed number of wait states per access
//   (WAIT_RD for reads, WAIT_WR for writes). Accesses whose word index
//   falls outside the memory complete normally but raise o_pslverr. They
//   never write, and they read back zero.
//
// Ports
//   i_pclk     clock, all state changes on the rising edge
//   i_preset   asynchronous active-high reset
//   i_psel     slave select
//   i_penable  access-phase indicator
//   i_pwrite   1 = write, 0 = read
//   i_paddr    byte address (low lane bits ignored)
//   i_pwdata   write data
//   i_pstrb    byte-lane write strobes
//   o_prdata   read data, non-zero only in the completing cycle of a read
//   o_pready   transfer complete
//   o_pslverr  transfer error (out-of-range), only alongside o_pready
module apb_mem_slave #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 64,
  parameter int WAIT_RD = 1,
  parameter int WAIT_WR = 0
) (
  input  logic                i_pclk,
  input  logic                i_preset,
  input  logic                i_psel,
  input  logic                i_penable,
  input  logic                i_pwrite,
  input  logic [ADDR_W-1:0]   i_paddr,
  input  logic [DATA_W-1:0]   i_pwdata,
  input  logic [DATA_W/8-1:0] i_pstrb,
  output logic [DATA_W-1:0]   o_prdata,
  output logic                o_pready,
  output logic                o_pslverr
);

  localparam int LANES  = DATA_W / 8;
  localparam int LSB    = $clog2(LANES);
  localparam int IDX_W  = ADDR_W - LSB;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    IDLE,
    ACCESS
  } stateType;

  stateType            r_state;
  stateType            w_nextState;
  logic [3:0]          r_cnt;
  logic [MEM_AW-1:0]   r_addr;
  logic                r_write;
  logic                r_inRange;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic [IDX_W-1:0]    w_setupIdx;
  logic                w_setupInRange;
  logic [3:0]          w_cntLoad;
  logic                w_load;
  logic                w_countDown;
  logic                w_ready;
  logic                w_commit;

  // Word index of the address on the bus. The lane-select bits below the
  // word boundary carry no meaning for a word-wide memory.
  assign w_setupIdx     = i_paddr[ADDR_W-1:LSB];
  assign w_setupInRange = (32'(w_setupIdx) < 32'(DEPTH));
  assign w_cntLoad      = i_pwrite ? 4'(WAIT_WR) : 4'(WAIT_RD);

  // The byte-offset bits are deliberately dropped; folding them into a
  // named sink keeps that decision visible.
  generate
    if (LSB > 0) begin : gLowBits
      logic w_unusedLowBits;
      assign w_unusedLowBits = ^i_paddr[LSB-1:0];
    end
  endgenerate

  // State register plus the context captured at every setup phase. Only the
  // low MEM_AW bits of the index are kept because the memory is touched only
  // when the range flag says the full index fits.
  always_ff @(posedge i_pclk or posedge i_preset) begin
    if (i_preset) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_inRange <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_load) begin
        r_cnt     <= w_cntLoad;
        r_addr    <= MEM_AW'(w_setupIdx);
        r_write   <= i_pwrite;
        r_inRange <= w_setupInRange;
      end else if (w_countDown) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Next-state logic. A setup phase is accepted from IDLE and also from
  // ACCESS, where it drops the pending transfer and starts a new one.
  // Losing PSEL mid-access aborts. PREADY rises only when the wait counter
  // has run out while the master holds the access phase.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_countDown = 1'b0;
    w_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_psel && !i_penable) begin
          w_nextState = ACCESS;
          w_load      = 1'b1;
        end
      end
      ACCESS: begin
        if (!i_psel) begin
          w_nextState = IDLE;
        end else if (!i_penable) begin
          w_load = 1'b1;
        end else if (r_cnt != 4'd0) begin
          w_countDown = 1'b1;
        end else begin
          w_ready     = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign w_commit = w_ready && r_write && r_inRange;

  // Memory array has no reset, so contents survive PRESET. A write can only
  // land on an edge where PREADY is high, and the asynchronous reset forces
  // IDLE first, which is what keeps a reset from committing a half-done write.
  always_ff @(posedge i_pclk) begin
    if (w_commit) begin
      for (int i = 0; i < LANES; i++) begin
        if (i_pstrb[i]) begin
          r_mem[r_addr][8*i +: 8] <= i_pwdata[8*i +: 8];
        end
      end
    end
  end

  // Response outputs are purely combinational from the FSM. Read data is
  // forced to zero except in the completing cycle of an in-range read.
  assign o_pready  = w_ready;
  assign o_pslverr = w_ready && !r_inRange;
  assign o_prdata  = (w_ready && r_inRange && !r_write) ? r_mem[r_addr] : '0;

endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave
//   Self-checking bench for apb_mem_slave. Two instances share the bus
//   wires. dut0 uses the default wait states, and dut1 uses WAIT_WR=2 for
//   the abort and re-setup scenarios. Each has its own PSEL. Expected
//   responses come from a word-array model of each memory with simple
//   latency and range rules.
module tb_apb_mem_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel0 = 1'b0;
  logic        psel1 = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [9:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;

  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1, pslverr0, pslverr1;

  logic [31:0] refMem0 [64];
  logic [31:0] refMem1 [64];

  int vecCount  = 0;
  int missCount = 0;

  always #5 clk = ~clk;

  apb_mem_slave dut0 (
    .i_pclk(clk), .i_preset(rst), .i_psel(psel0), .i_penable(penable),
    .i_pwrite(pwrite), .i_paddr(paddr), .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_prdata(prdata0), .o_pready(pready0), .o_pslverr(pslverr0)
  );

  apb_mem_slave #(.WAIT_WR(2)) dut1 (
    .i_pclk(clk), .i_preset(rst), .i_psel(psel1), .i_penable(penable),
    .i_pwrite(pwrite), .i_paddr(paddr), .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_prdata(prdata1), .o_pready(pready1), .o_pslverr(pslverr1)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic sampleUnit(input int unit, output logic rdy, output logic err, output logic [31:0] rd);
    if (unit == 1) begin
      rdy = pready1; err = pslverr1; rd = prdata1;
    end else begin
      rdy = pready0; err = pslverr0; rd = prdata0;
    end
  endtask

  task automatic selUnit(input int unit, input logic v);
    if (unit == 1) psel1 = v;
    else psel0 = v;
  endtask

  // Full transfer: one setup cycle, then exactly WAIT+1 access cycles with
  // PREADY low until the last. The model memory is updated after the
  // completing edge. When scramble is set, address and direction are
  // disturbed during the access phase; the slave must use the latched values.
  task automatic applyStimulus(input int unit, input bit wr, input logic [9:0] addr,
                               input logic [31:0] data, input logic [3:0] strb, input bit scramble);
    int          idx, waitExp;
    bit          inRange;
    logic [31:0] expRd, rd;
    logic        rdy, err;
    idx     = int'(addr >> 2);
    inRange = (idx < 64);
    waitExp = wr ? ((unit == 1) ? 2 : 0) : 1;
    if (!wr && inRange) expRd = (unit == 1) ? refMem1[idx] : refMem0[idx];
    else expRd = 32'h0;
    selUnit(unit, 1'b1);
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    if (scramble) begin
      paddr  = 10'($urandom);
      pwrite = ~wr;
    end
    for (int c = 0; c <= waitExp; c++) begin
      @(negedge clk);
      sampleUnit(unit, rdy, err, rd);
      if (c < waitExp) begin
        checkOutput("waitReady", {31'b0, rdy}, 32'h0);
        checkOutput("waitData", rd, 32'h0);
      end else begin
        checkOutput("ready", {31'b0, rdy}, 32'h1);
        checkOutput("slverr", {31'b0, err}, {31'b0, !inRange});
        checkOutput("rdata", rd, expRd);
      end
      @(posedge clk); #1;
    end
    if (wr && inRange) begin
      for (int l = 0; l < 4; l++) begin
        if (strb[l]) begin
          if (unit == 1) refMem1[idx][8*l +: 8] = data[8*l +: 8];
          else refMem0[idx][8*l +: 8] = data[8*l +: 8];
        end
      end
    end
    selUnit(unit, 1'b0);
    penable = 1'b0;
  endtask

  // PSEL and PENABLE both high with no preceding setup phase must never
  // produce PREADY.
  task automatic holdNoSetup(input int unit, input int cycles, input string tag);
    logic        rdy, err;
    logic [31:0] rd;
    selUnit(unit, 1'b1);
    penable = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      sampleUnit(unit, rdy, err, rd);
      checkOutput(tag, {31'b0, rdy}, 32'h0);
      @(posedge clk); #1;
    end
    selUnit(unit, 1'b0);
    penable = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected summary first");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit          wr;
    logic [9:0]  a;
    logic [31:0] d;
    logic [3:0]  s;

    // Reset state of both instances
    #2;
    checkOutput("rstReady0", {31'b0, pready0}, 32'h0);
    checkOutput("rstErr0", {31'b0, pslverr0}, 32'h0);
    checkOutput("rstData0", prdata0, 32'h0);
    checkOutput("rstReady1", {31'b0, pready1}, 32'h0);
    checkOutput("rstErr1", {31'b0, pslverr1}, 32'h0);
    checkOutput("rstData1", prdata1, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    holdNoSetup(0, 3, "noSetup");

    // Fill every word of dut0 so random reads have known contents
    for (int i = 0; i < 64; i++) applyStimulus(0, 1'b1, 10'(i * 4), $urandom, 4'hF, 1'b0);

    // Directed scenarios on the default instance
    applyStimulus(0, 1'b1, 10'h010, 32'hA5A51234, 4'hF, 1'b0);
    applyStimulus(0, 1'b0, 10'h010, 32'h0, 4'h0, 1'b0);
    applyStimulus(0, 1'b1, 10'h020, 32'h00000000, 4'hF, 1'b0);
    applyStimulus(0, 1'b1, 10'h020, 32'hFFFFFFFF, 4'b0101, 1'b0);
    applyStimulus(0, 1'b0, 10'h020, 32'h0, 4'h0, 1'b0);
    checkOutput("strbModel", refMem0[8], 32'h00FF00FF);
    applyStimulus(0, 1'b1, 10'h100, 32'hDEADBEEF, 4'hF, 1'b0);
    applyStimulus(0, 1'b0, 10'h100, 32'h0, 4'h0, 1'b0);
    applyStimulus(0, 1'b1, 10'h0FC, 32'hCAFEF00D, 4'hF, 1'b0);
    applyStimulus(0, 1'b0, 10'h0FC, 32'h0, 4'h0, 1'b0);
    applyStimulus(0, 1'b1, 10'h000, 32'h13579BDF, 4'hF, 1'b0);
    applyStimulus(0, 1'b0, 10'h000, 32'h0, 4'h0, 1'b0);

    // Reset during the completing cycle of a write: outputs drop at once
    // and the write never lands
    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h010;
    pwdata = 32'h55555555; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    checkOutput("preRstReady", {31'b0, pready0}, 32'h1);
    #1 rst = 1'b1;
    #1;
    checkOutput("rstWrReady", {31'b0, pready0}, 32'h0);
    checkOutput("rstWrErr", {31'b0, pslverr0}, 32'h0);
    psel0 = 1'b0; penable = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Reset during the wait cycle of a read
    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 10'h010;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    checkOutput("rdWaitReady", {31'b0, pready0}, 32'h0);
    #1 rst = 1'b1;
    #1;
    checkOutput("rstRdReady", {31'b0, pready0}, 32'h0);
    checkOutput("rstRdErr", {31'b0, pslverr0}, 32'h0);
    checkOutput("rstRdData", prdata0, 32'h0);
    psel0 = 1'b0; penable = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    holdNoSetup(0, 2, "postRstNoSetup");
    applyStimulus(0, 1'b0, 10'h010, 32'h0, 4'h0, 1'b0);

    // Abort on the WAIT_WR=2 instance: PSEL dropped in the 2nd access cycle
    applyStimulus(1, 1'b1, 10'h004, 32'h11111111, 4'hF, 1'b0);
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h004;
    pwdata = 32'h22222222; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    checkOutput("abortCyc1", {31'b0, pready1}, 32'h0);
    @(posedge clk); #1;
    psel1 = 1'b0;
    @(negedge clk);
    checkOutput("abortCyc2", {31'b0, pready1}, 32'h0);
    @(posedge clk); #1;
    penable = 1'b0;
    holdNoSetup(1, 3, "abortIdle");
    applyStimulus(1, 1'b0, 10'h004, 32'h0, 4'h0, 1'b0);

    // New setup phase in the middle of an access drops the pending write
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h004;
    pwdata = 32'h33333333; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    checkOutput("violCyc1", {31'b0, pready1}, 32'h0);
    @(posedge clk); #1;
    applyStimulus(1, 1'b1, 10'h008, 32'h44444444, 4'hF, 1'b0);
    applyStimulus(1, 1'b0, 10'h004, 32'h0, 4'h0, 1'b0);
    applyStimulus(1, 1'b0, 10'h008, 32'h0, 4'h0, 1'b0);

    // Random traffic on dut0, mostly in range, with occasional idle gaps
    // and access-phase disturbances
    for (int n = 0; n < 300; n++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = 10'($urandom_range(256, 1023));
      else a = 10'($urandom_range(0, 255));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      applyStimulus(0, wr, a, d, s, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
